if_queue: RTL and testbench
===========================

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 32, instruction address width.
REQ-003 Parameter INST_W, default 32, instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid_i  input  1  fetch stage offers an instruction.
REQ-007 in_ready_o  output  1  queue accepts an instruction this cycle.
REQ-008 inst_i  input  INST_W  fetched instruction.
REQ-009 inst_addr_i  input  ADDR_W  address of inst_i.
REQ-010 flush_i  input  1  jump taken; discard all queued entries.
REQ-011 hold_i  input  1  decode stall; no entry is consumed.
REQ-012 out_valid_o  output  1  head entry present and presented to decode.
REQ-013 inst_o  output  INST_W  head instruction; NOP when empty.
REQ-014 inst_addr_o  output  ADDR_W  head address; zero when empty.
REQ-015 count_o  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 Push occurs when in_valid_i and in_ready_o are both high and flush_i is low.
REQ-017 Pop occurs when out_valid_o is high, hold_i is low and flush_i is low.
REQ-018 in_ready_o is high exactly when count_o is less than DEPTH; there is no pop-through when full.
REQ-019 out_valid_o is high exactly when count_o is nonzero.
REQ-020 A pushed entry first appears on the outputs one cycle after the push; there is no bypass from input to output.
REQ-021 Simultaneous push and pop leave count_o unchanged, with the head advancing and the new entry written at the tail.
REQ-022 Read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-023 flush_i has priority over push and pop: on the next edge both pointers and count_o are 0, and the offered input is dropped.
REQ-024 hold_i high with out_valid_o high keeps inst_o and inst_addr_o stable; pushes continue while not full.
REQ-025 A push attempted while full is ignored, and a pop attempted while empty is ignored; no state changes in either case.
REQ-026 While empty, inst_o equals INST_NOP (32'h00000013) and inst_addr_o is 0.
REQ-027 Outputs are driven from the head storage entry only; out_valid_o, in_ready_o and count_o depend on registered state only.

Reset
REQ-028 rst low asynchronously clears the pointers and count_o, independent of clk.
REQ-029 During reset: out_valid_o 0, in_ready_o 0, count_o 0, inst_o INST_NOP, inst_addr_o 0.
REQ-030 in_ready_o rises on the first rising edge after rst deasserts.
REQ-031 Storage array contents are not reset.
REQ-032 Reset asserted mid-operation discards all entries, identically to a flush.

Structure
REQ-033 INST_NOP, ZERO_WORD, and the instruction and address bus widths reside in the shared defines header; no local copies are made.
REQ-034 The storage array is a sub-module, fifo_mem: synchronous write, combinational read, parametrised in DEPTH and INST_W+ADDR_W.
REQ-035 Pointer and count logic stays in if_queue; there is no FSM beyond the counter and pointers.

Verification (DEPTH=4)
REQ-036 Bench: push 0x00500093@0x0 with hold_i=0 -> next cycle out_valid_o=1, inst_o=0x00500093, inst_addr_o=0x0, count_o=1.
REQ-037 Bench: hold_i=1, push 5 instructions @0x0..0x10 -> count_o=4, in_ready_o=0, fifth instruction not accepted, inst_addr_o stays 0x0.
REQ-038 Bench: from full, release hold_i with in_valid_i held high -> addresses 0x0,0x4,0x8,0xC,0x10 emerge in order; pointer wrap verified.
REQ-039 Bench: count_o=3, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, inst_o=0x00000013.
REQ-040 Bench: rst=0 asynchronously between edges with count_o=2 -> count_o=0 and out_valid_o=0 immediately, without waiting for a clock edge.
REQ-041 Bench: count_o=2 with push and pop in the same cycle -> count_o stays 2 and the head address advances by 4.

Source files
------------

// File: rtl/if_queue_pkg.sv
// Shared defines for the instruction-fetch queue: bus widths and the words
// presented to decode when the queue has nothing to offer.
package if_queue_pkg;

    localparam int IQ_INST_W = 32;
    localparam int IQ_ADDR_W = 32;

    // addi x0, x0, 0 -- canonical RISC-V NOP
    localparam logic [IQ_INST_W-1:0] INST_NOP  = 32'h0000_0013;
    localparam logic [IQ_ADDR_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_queue_fifo_mem.sv
// Storage array for the fetch queue: one write port clocked on the rising
// edge, one combinational read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction-fetch queue between fetch and decode. Pointer/count bookkeeping
// lives here; entry storage is the fifo_mem sub-module.
module if_queue
    import if_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = IQ_ADDR_W,
    parameter int INST_W = IQ_INST_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INST_W-1:0]      inst_i,
    input  logic [ADDR_W-1:0]      inst_addr_i,
    input  logic                   flush_i,
    input  logic                   hold_i,
    output logic                   out_valid_o,
    output logic [INST_W-1:0]      inst_o,
    output logic [ADDR_W-1:0]      inst_addr_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INST_W + ADDR_W;

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [INST_W-1:0] EMPTY_INST = INST_W'(INST_NOP);
    localparam logic [ADDR_W-1:0] EMPTY_ADDR = ADDR_W'(ZERO_WORD);

    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               ready_en_q;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake: an entry transfers in on any rising edge where in_valid_i
    // and in_ready_o are both high, and out to decode on any edge where
    // out_valid_o is high and hold_i is low. flush_i cancels both transfers.
    // Ready/valid are functions of registered state only, never of inputs.
    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & ~hold_i & ~flush_i;

    // ready_en_q keeps the input closed until the first edge after reset.
    assign in_ready_o  = ready_en_q & (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign count_o     = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                // Power-of-two depth: pointers wrap naturally at DEPTH-1.
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign wr_entry = {inst_i, inst_addr_i};

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Stale storage is masked so decode sees a clean NOP at address zero.
    assign inst_o      = out_valid_o ? head_entry[ENTRY_W-1:ADDR_W] : EMPTY_INST;
    assign inst_addr_o = out_valid_o ? head_entry[ADDR_W-1:0]       : EMPTY_ADDR;

endmodule

// File: tb/tb_if_queue.sv
// Bench for if_queue (DEPTH=4): directed vector table, async reset sequences
// and a random phase, all checked against a queue-based reference model.
module tb_if_queue;
    import if_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] inst_in = '0;
    logic [AW-1:0] addr_in = '0;
    logic          flush = 1'b0;
    logic          hold = 1'b0;
    logic          out_valid;
    logic [IW-1:0] inst_out;
    logic [AW-1:0] addr_out;
    logic [CW-1:0] count;

    if_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .INST_W (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_i      (inst_in),
        .inst_addr_i (addr_in),
        .flush_i     (flush),
        .hold_i      (hold),
        .out_valid_o (out_valid),
        .inst_o      (inst_out),
        .inst_addr_o (addr_out),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: queued {inst, addr} entries plus the post-reset ready gate
    logic [IW+AW-1:0] exp_q[$];
    logic             m_ready_en = 1'b0;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic          h;
        logic          f;
        int            cnt;
        logic          vld;
        logic          rdy;
        logic [AW-1:0] head;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
        return 32'h0050_0093 + (a << 18);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [IW+AW-1:0] hd;
        int               sz;
        sz = exp_q.size();
        check({tag, "_count"}, 64'(count), 64'(sz));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(sz != 0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(m_ready_en && (sz < DEPTH)));
        if (sz != 0) begin
            hd = exp_q[0];
            check({tag, "_inst"}, 64'(inst_out), 64'(hd[IW+AW-1:AW]));
            check({tag, "_addr"}, 64'(addr_out), 64'(hd[AW-1:0]));
        end else begin
            check({tag, "_inst"}, 64'(inst_out), 64'(INST_NOP));
            check({tag, "_addr"}, 64'(addr_out), 64'(ZERO_WORD));
        end
    endtask

    // One clock: drive inputs, score any pop against the queue head, step the
    // model, then compare the full post-edge state.
    task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic [AW-1:0] a,
                         input logic h, input logic f);
        logic             do_push;
        logic             do_pop;
        logic [IW+AW-1:0] hd;
        in_valid = v;
        inst_in  = ins;
        addr_in  = a;
        hold     = h;
        flush    = f;
        do_push  = v && m_ready_en && (exp_q.size() < DEPTH) && !f;
        do_pop   = (exp_q.size() != 0) && !h && !f;
        if (do_pop) begin
            hd = exp_q.pop_front();
            check("pop_inst", 64'(inst_out), 64'(hd[IW+AW-1:AW]));
            check("pop_addr", 64'(addr_out), 64'(hd[AW-1:0]));
        end
        if (f) begin
            exp_q.delete();
        end else if (do_push) begin
            exp_q.push_back({ins, a});
        end
        @(posedge clk);
        #1;
        m_ready_en = 1'b1;
        check_state("step");
    endtask

    task automatic add_row(input logic v, input logic [AW-1:0] a, input logic h, input logic f,
                           input int cnt, input logic vld, input logic rdy, input logic [AW-1:0] head);
        vec_t r;
        r.v = v; r.a = a; r.h = h; r.f = f;
        r.cnt = cnt; r.vld = vld; r.rdy = rdy; r.head = head;
        vecs.push_back(r);
    endtask

    initial begin
        logic [AW-1:0] nxt_addr;
        logic [IW-1:0] exp_inst;
        vec_t          r;

        //       v  addr   h  f  cnt vld rdy head
        add_row(1, 'h00, 0, 0, 1, 1, 1, 'h00);  // single push, no bypass
        add_row(0, 'h00, 0, 0, 0, 0, 1, 'h00);
        add_row(0, 'h00, 0, 0, 0, 0, 1, 'h00);  // pop while empty ignored
        add_row(1, 'h00, 1, 0, 1, 1, 1, 'h00);  // fill under hold
        add_row(1, 'h04, 1, 0, 2, 1, 1, 'h00);
        add_row(1, 'h08, 1, 0, 3, 1, 1, 'h00);
        add_row(1, 'h0C, 1, 0, 4, 1, 0, 'h00);
        add_row(1, 'h10, 1, 0, 4, 1, 0, 'h00);  // fifth rejected when full
        add_row(1, 'h10, 0, 0, 3, 1, 1, 'h04);  // no pop-through when full
        add_row(1, 'h10, 0, 0, 3, 1, 1, 'h08);  // 0x10 lands at wrapped slot 0
        add_row(0, 'h00, 0, 0, 2, 1, 1, 'h0C);
        add_row(0, 'h00, 0, 0, 1, 1, 1, 'h10);
        add_row(0, 'h00, 0, 0, 0, 0, 1, 'h00);
        add_row(1, 'h20, 1, 0, 1, 1, 1, 'h20);
        add_row(1, 'h24, 1, 0, 2, 1, 1, 'h20);
        add_row(1, 'h28, 1, 0, 3, 1, 1, 'h20);
        add_row(1, 'h2C, 1, 1, 0, 0, 1, 'h00);  // flush drops queue and input
        add_row(0, 'h00, 0, 0, 0, 0, 1, 'h00);
        add_row(1, 'h30, 1, 0, 1, 1, 1, 'h30);
        add_row(1, 'h34, 1, 0, 2, 1, 1, 'h30);
        add_row(1, 'h38, 0, 0, 2, 1, 1, 'h34);  // push+pop at count 2
        add_row(1, 'h3C, 0, 0, 2, 1, 1, 'h38);

        // reset held, then released between edges
        #12;
        check("rst_count", 64'(count), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_inst", 64'(inst_out), 64'(32'h0000_0013));
        check("rst_addr", 64'(addr_out), 64'(0));
        rst = 1'b1;
        #1;
        check("ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        m_ready_en = 1'b1;
        check("ready_after_edge", 64'(in_ready), 64'(1));

        for (int i = 0; i < vecs.size(); i++) begin
            r = vecs[i];
            cycle(r.v, inst_of(r.a), r.a, r.h, r.f);
            exp_inst = r.vld ? inst_of(r.head) : 32'h0000_0013;
            check($sformatf("row%0d_count", i), 64'(count), 64'(r.cnt));
            check($sformatf("row%0d_valid", i), 64'(out_valid), 64'(r.vld));
            check($sformatf("row%0d_ready", i), 64'(in_ready), 64'(r.rdy));
            check($sformatf("row%0d_addr", i), 64'(addr_out), 64'(r.head));
            check($sformatf("row%0d_inst", i), 64'(inst_out), 64'(exp_inst));
        end

        // asynchronous reset mid-operation with two entries queued
        in_valid = 1'b0;
        hold     = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'(0));
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_inst", 64'(inst_out), 64'(32'h0000_0013));
        exp_q.delete();
        m_ready_en = 1'b0;
        check_state("async_rst");
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_ready_en = 1'b1;
        check_state("post_rst");
        cycle(1'b1, inst_of('h40), 'h40, 1'b1, 1'b0);
        check("post_rst_addr", 64'(addr_out), 64'('h40));

        // random traffic against the model
        nxt_addr = 'h100;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, IW'($urandom), nxt_addr,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            nxt_addr = nxt_addr + 4;
        end
        for (int i = 0; i <= DEPTH; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        check("drained_count", 64'(count), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
